// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Brief    : Pipeline stall/flush/freeze controller with stall timeout and
//            saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int CNT_W     = 16,
    parameter int FLUSH_LEN = 2,
    parameter int MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             clr_timeout,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             global_stall,
    output logic [1:0]       state,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam logic [2:0]       c_FLUSH_INIT = 3'(FLUSH_LEN - 1);
    localparam logic [7:0]       c_MAX_STALL  = 8'(MAX_STALL);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_MEMW  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     r_ret;
    logic [2:0] r_cnt;
    logic [7:0] r_streak;

    logic w_active;
    logic w_flush_req;
    logic w_haz_req;
    logic w_to_set;

    assign w_active    = (r_state == ST_RUN) || (r_state == ST_HAZ);
    assign w_flush_req = (r_state == ST_FLUSH) || (w_active && branch_taken);
    assign w_haz_req   = w_active && hazard_detected;
    // Timeout fires only on the increment that lands exactly on MAX_STALL.
    assign w_to_set    = !mem_busy && !w_flush_req && w_haz_req &&
                         (r_streak != c_MAX_STALL) &&
                         ((r_streak + 8'd1) == c_MAX_STALL);
    assign state       = r_state;

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        global_stall = 1'b0;
        if (rst) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            global_stall = 1'b1;
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
        end else if (w_flush_req) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_haz_req) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_ret         <= ST_RUN;
            r_cnt         <= 3'd0;
            r_streak      <= 8'd0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
            flush_cycles  <= '0;
        end else begin
            if (w_to_set) begin
                stall_timeout <= 1'b1;
            end else if (clr_timeout) begin
                stall_timeout <= 1'b0;
            end

            if (mem_busy) begin
                if (r_state != ST_MEMW) begin
                    r_ret <= r_state;
                end
                r_state <= ST_MEMW;
            end else if (r_state == ST_MEMW) begin
                r_state <= r_ret;
            end else if (r_state == ST_FLUSH) begin
                if (flush_cycles != c_CNT_MAX) begin
                    flush_cycles <= flush_cycles + c_CNT_ONE;
                end
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    r_state <= ST_RUN;
                end
            end else if (branch_taken) begin
                if (flush_cycles != c_CNT_MAX) begin
                    flush_cycles <= flush_cycles + c_CNT_ONE;
                end
                r_cnt    <= c_FLUSH_INIT;
                r_streak <= 8'd0;
                r_state  <= (FLUSH_LEN > 1) ? ST_FLUSH : ST_RUN;
            end else if (hazard_detected) begin
                if (stall_cycles != c_CNT_MAX) begin
                    stall_cycles <= stall_cycles + c_CNT_ONE;
                end
                if (r_streak != c_MAX_STALL) begin
                    r_streak <= r_streak + 8'd1;
                end
                r_state <= ST_HAZ;
            end else begin
                r_streak <= 8'd0;
                r_state  <= ST_RUN;
            end
        end
    end

endmodule
`default_nettype wire
